// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 scan-code sequencer.
package ps2_pkg;

  // Prefix-tracking state of the scan-code sequencer.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } seq_state_t;

  // Extended-key and break (key release) prefix bytes.
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // One completed key event as stored in the event FIFO.
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } key_evt_t;

  // Device status/acknowledge bytes that never belong to a key event.
  function automatic logic is_status_byte(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA,
      8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word fall-through FIFO of key events. A push while full is accepted
// only when a pop happens in the same cycle.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     CLK,
  input  logic     RST_N,
  input  logic     push_i,
  input  key_evt_t data_i,
  input  logic     pop_i,
  output key_evt_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  key_evt_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic            push_ok;
  logic            pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_CNT);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_i);

  // Head is forced to zero when empty so outputs are defined right after reset.
  assign head_o = empty_o ? key_evt_t'('0) : mem_q[rd_ptr_q];

  // Storage write; contents are don't-care until the count covers them.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping; power-of-two depth gives natural wrap.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_sequencer.sv
// Turns a raw PS/2 scan-code byte stream into buffered key events, handling
// E0/F0 prefixes, status bytes, frame errors and stalled prefix sequences.
module ps2_scancode_sequencer
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       byte_err,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic [7:0] last_make,
  output logic       overflow,
  input  logic       clr_overflow
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  seq_state_t    state_q;
  logic [TW-1:0] timer_q;
  logic [7:0]    last_make_q;
  logic          overflow_q;

  logic          is_ext;
  logic          is_brk;
  logic          drop_byte;
  logic          emit;
  key_evt_t      emit_evt;
  key_evt_t      head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          evt_dropped;

  assign is_ext    = (byte_data == PS2_EXT);
  assign is_brk    = (byte_data == PS2_BRK);
  assign drop_byte = byte_err | is_status_byte(byte_data);

  // Any accepted non-prefix byte completes an event; ext/brk come from the
  // prefixes already collected in the current state.
  assign emit = byte_valid & ~drop_byte & ~is_ext & ~is_brk;

  // Assemble the event pushed into the FIFO this cycle.
  always_comb begin
    emit_evt      = '0;
    emit_evt.code = byte_data;
    emit_evt.ext  = (state_q == GOT_E0) || (state_q == GOT_E0F0);
    emit_evt.brk  = (state_q == GOT_F0) || (state_q == GOT_E0F0);
  end

  // Prefix FSM plus the stall timer that abandons an incomplete sequence.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else if (byte_valid) begin
      timer_q <= '0;
      if (drop_byte) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (is_ext)      state_q <= GOT_E0;
            else if (is_brk) state_q <= GOT_F0;
          end
          GOT_E0: begin
            if (is_brk)       state_q <= GOT_E0F0;
            else if (!is_ext) state_q <= IDLE;
          end
          GOT_F0: begin
            if (is_ext)       state_q <= GOT_E0F0;
            else if (!is_brk) state_q <= IDLE;
          end
          GOT_E0F0: begin
            if (!(is_ext || is_brk)) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end else if (state_q != IDLE) begin
      if (timer_q == TIMER_LAST) begin
        state_q <= IDLE;
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + TW'(1);
      end
    end else begin
      timer_q <= '0;
    end
  end

  assign pop         = ~fifo_empty & evt_ready;
  assign evt_dropped = emit & fifo_full & ~pop;

  // Most recent make code (tracked even if the event itself is dropped) and
  // sticky overflow where a new drop outranks a simultaneous clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_make_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (emit && !emit_evt.brk) last_make_q <= byte_data;
      if (evt_dropped)           overflow_q  <= 1'b1;
      else if (clr_overflow)     overflow_q  <= 1'b0;
    end
  end

  ps2_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .push_i (emit),
    .data_i (emit_evt),
    .pop_i  (pop),
    .head_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign evt_valid = ~fifo_empty;
  assign evt_code  = head.code;
  assign evt_ext   = head.ext;
  assign evt_break = head.brk;
  assign last_make = last_make_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// Directed bench with an expected-event scoreboard for the scan-code sequencer.
module tb_ps2_scancode_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 2000;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_err = 1'b0;
  logic       evt_ready = 1'b1;
  logic       clr_overflow = 1'b0;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic [7:0] last_make;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q [$];

  ps2_scancode_sequencer #(
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_err    (byte_err),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_code    (evt_code),
    .evt_ext     (evt_ext),
    .evt_break   (evt_break),
    .last_make   (last_make),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted head is compared with the oldest expectation.
  always @(negedge CLK) begin
    if (RST_N && evt_valid && evt_ready) begin
      $display("evt code=%02h ext=%0b brk=%0b", evt_code, evt_ext, evt_break);
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_evt observed=%0h expected=none", {evt_code, evt_ext, evt_break});
      end
      if (exp_q.size() > 0) chk("evt", {22'd0, evt_code, evt_ext, evt_break}, {22'd0, exp_q.pop_front()});
    end
  end

  task automatic expect_evt(input logic [7:0] code, input logic ext, input logic brk);
    exp_q.push_back({code, ext, brk});
  endtask

  task automatic send(input logic [7:0] b, input logic err = 1'b0);
    @(posedge CLK); #1;
    byte_valid = 1'b1; byte_data = b; byte_err = err;
    @(posedge CLK); #1;
    byte_valid = 1'b0; byte_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Bounded wait for all expected events to be consumed.
  task automatic drain(input string tag);
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) begin
      @(posedge CLK); #1;
    end
    idle(3);
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_valid", evt_valid, 0);
    chk("rst_code", evt_code, 0);
    chk("rst_ext_brk", {evt_ext, evt_break}, 0);
    chk("rst_last_make", last_make, 0);
    chk("rst_overflow", overflow, 0);
    @(posedge CLK); #1; RST_N = 1'b1;
    idle(2);
    chk("post_rst_valid", evt_valid, 0);

    // Make, then break with long gaps
    expect_evt(8'h75, 0, 0); send(8'h75);
    idle(1000); send(8'hF0); idle(1000);
    expect_evt(8'h75, 0, 1); send(8'h75);
    drain("make_break");
    chk("last_make_75", last_make, 8'h75);

    // Extended make and break
    expect_evt(8'h75, 1, 0); send(8'hE0); send(8'h75);
    expect_evt(8'h75, 1, 1); send(8'hE0); send(8'hF0); send(8'h75);
    drain("ext_make_break");

    // Reversed and repeated prefixes, E1 as ordinary code
    expect_evt(8'h75, 1, 1); send(8'hF0); send(8'hE0); send(8'h75);
    expect_evt(8'h71, 1, 1); send(8'hE0); send(8'hE0); send(8'hF0); send(8'hF0); send(8'h71);
    expect_evt(8'h12, 0, 1); send(8'hF0); send(8'hF0); send(8'h12);
    expect_evt(8'hE1, 0, 0); send(8'hE1);
    drain("prefix_variants");
    chk("last_make_e1", last_make, 8'hE1);

    // Errored frames are discarded
    send(8'hF0, 1'b1);
    expect_evt(8'h1C, 0, 0); send(8'h1C);
    send(8'h23, 1'b1);
    drain("err_discard");
    chk("last_make_1c", last_make, 8'h1C);

    // Status bytes dropped, also mid-sequence
    expect_evt(8'h1C, 0, 0); send(8'h1C);
    send(8'hAA); send(8'hFA);
    expect_evt(8'h32, 0, 0); send(8'h32);
    send(8'hE0); send(8'hFA);
    expect_evt(8'h5A, 0, 0); send(8'h5A);
    drain("status_drop");

    // Back-to-back bytes on consecutive cycles
    expect_evt(8'h4A, 1, 1); expect_evt(8'h1A, 0, 0); expect_evt(8'h1B, 0, 0);
    @(posedge CLK); #1; byte_valid = 1'b1; byte_data = 8'hE0;
    @(posedge CLK); #1; byte_data = 8'hF0;
    @(posedge CLK); #1; byte_data = 8'h4A;
    @(posedge CLK); #1; byte_data = 8'h1A;
    @(posedge CLK); #1; byte_data = 8'h1B;
    @(posedge CLK); #1; byte_valid = 1'b0;
    drain("back_to_back");

    // Timeout abandons a stalled break prefix
    send(8'hF0); idle(TMO);
    expect_evt(8'h1C, 0, 0); send(8'h1C);
    drain("timeout");
    // Just inside the timeout the prefix still applies
    send(8'hF0); idle(TMO - 3);
    expect_evt(8'h1C, 0, 1); send(8'h1C);
    drain("no_timeout");

    // Overflow with consumer stalled
    evt_ready = 1'b0;
    expect_evt(8'h15, 0, 0); expect_evt(8'h1D, 0, 0);
    expect_evt(8'h24, 0, 0); expect_evt(8'h2D, 0, 0);
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
    chk("ovf_set", overflow, 1);
    chk("ovf_last_make", last_make, 8'h2C);
    chk("ovf_valid", evt_valid, 1);
    idle(3);
    chk("head_stable", evt_code, 8'h15);
    evt_ready = 1'b1;
    drain("ovf_drain");
    chk("drained_valid", evt_valid, 0);
    chk("ovf_sticky", overflow, 1);
    @(posedge CLK); #1; clr_overflow = 1'b1;
    @(posedge CLK); #1; clr_overflow = 1'b0;
    chk("ovf_clear", overflow, 0);

    // Push plus pop while full keeps occupancy at DEPTH
    evt_ready = 1'b0;
    expect_evt(8'h16, 0, 0); expect_evt(8'h1E, 0, 0);
    expect_evt(8'h26, 0, 0); expect_evt(8'h25, 0, 0);
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
    chk("full_no_ovf", overflow, 0);
    expect_evt(8'h3C, 0, 0);
    @(posedge CLK); #1; evt_ready = 1'b1; byte_valid = 1'b1; byte_data = 8'h3C;
    @(posedge CLK); #1; evt_ready = 1'b0; byte_valid = 1'b0;
    chk("push_pop_full", overflow, 0);
    // Still full: next push drops, and the drop beats a same-cycle clear
    @(posedge CLK); #1; byte_valid = 1'b1; byte_data = 8'h4B; clr_overflow = 1'b1;
    @(posedge CLK); #1; byte_valid = 1'b0; clr_overflow = 1'b0;
    chk("set_beats_clear", overflow, 1);
    chk("last_make_4b", last_make, 8'h4B);
    chk("full_head", evt_code, 8'h1E);
    evt_ready = 1'b1;
    drain("full_drain");

    // Reset mid-sequence and mid-FIFO
    evt_ready = 1'b0;
    send(8'hE0); send(8'h29); send(8'h11); send(8'h12); send(8'h13); send(8'h14);
    send(8'hF0);
    chk("pre_rst_ovf", overflow, 1);
    RST_N = 1'b0;
    #2;
    chk("mid_rst_valid", evt_valid, 0);
    chk("mid_rst_code", evt_code, 0);
    chk("mid_rst_last_make", last_make, 0);
    chk("mid_rst_ovf", overflow, 0);
    @(posedge CLK); #1; RST_N = 1'b1;
    evt_ready = 1'b1;
    expect_evt(8'h1C, 0, 0); send(8'h1C);
    drain("after_rst");

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
